// File: rtl/tie_mon_pkg.sv
// Shared types for the tie-net level monitor: FSM states and fault_code bit positions.
package tie_mon_pkg;

  typedef enum logic [1:0] {
    ST_WARMUP  = 2'd0,
    ST_MONITOR = 2'd1,
    ST_FAULT   = 2'd2,
    ST_CLEAR   = 2'd3
  } state_t;

  localparam int FC_HI = 0;
  localparam int FC_LO = 1;

endpackage

// File: rtl/tie_sync2.sv
// Two-flop synchronizer with a selectable reset level; 2-cycle latency, no flow control.
module tie_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic ck,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge ck) begin
    if (rst) begin
      r_s1 <= RST_VAL;
      r_s2 <= RST_VAL;
    end else begin
      r_s1 <= d;
      r_s2 <= r_s1;
    end
  end

  assign q = r_s2;

endmodule

// File: rtl/tie_level_monitor.sv
// Debounced stuck/glitch detector for tie-high/tie-low nets with sticky fault and req/ack clear.
// Deviation at cycle t raises fault at edge t+2+THRESH; clear is acked one cycle after an edge-qualified request.
module tie_level_monitor
  import tie_mon_pkg::*;
#(
  parameter int WARMUP = 3,
  parameter int THRESH = 4,
  parameter int CNT_W  = 8
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             en,
  input  logic             tie_hi,
  input  logic             tie_lo,
  input  logic             clr_req,
  output logic             clr_ack,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int WCNT_W = $clog2(WARMUP + 1);

  state_t              r_state, w_state_nxt;
  logic [WCNT_W-1:0]   r_wcnt, w_wcnt_nxt;
  logic [CNT_W-1:0]    r_dcnt, w_dcnt_nxt;
  logic [CNT_W-1:0]    r_err, w_err_nxt;
  logic [1:0]          r_code, w_code_nxt;
  logic                r_fault, w_fault_nxt;
  logic                r_ack, w_ack_nxt;
  logic                r_armed, w_armed_nxt;
  logic                w_sync_hi, w_sync_lo;
  logic                w_mis_hi, w_mis_lo, w_mis;
  logic                w_clr;

  tie_sync2 #(.RST_VAL(1'b1)) u_sync_hi (.ck(ck), .rst(rst), .d(tie_hi), .q(w_sync_hi));
  tie_sync2 #(.RST_VAL(1'b0)) u_sync_lo (.ck(ck), .rst(rst), .d(tie_lo), .q(w_sync_lo));

  assign w_mis_hi = ~w_sync_hi;
  assign w_mis_lo = w_sync_lo;
  assign w_mis    = w_mis_hi | w_mis_lo;
  // A request counts only once clr_req has been observed low since the last ack.
  assign w_clr    = clr_req & r_armed;

  always_ff @(posedge ck) begin
    if (rst) begin
      r_state <= ST_WARMUP;
      r_wcnt  <= '0;
      r_dcnt  <= '0;
      r_err   <= '0;
      r_code  <= 2'b00;
      r_fault <= 1'b0;
      r_ack   <= 1'b0;
      r_armed <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_dcnt  <= w_dcnt_nxt;
      r_err   <= w_err_nxt;
      r_code  <= w_code_nxt;
      r_fault <= w_fault_nxt;
      r_ack   <= w_ack_nxt;
      r_armed <= w_armed_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_dcnt_nxt  = r_dcnt;
    w_err_nxt   = r_err;
    w_code_nxt  = r_code;
    w_fault_nxt = r_fault;
    w_ack_nxt   = 1'b0;
    w_armed_nxt = r_armed | ~clr_req;
    case (r_state)
      ST_WARMUP: begin
        w_dcnt_nxt = '0;
        if (w_clr) begin
          w_ack_nxt   = 1'b1;
          w_armed_nxt = 1'b0;
          w_wcnt_nxt  = '0;
        end else if (r_wcnt == WCNT_W'(WARMUP - 1)) begin
          w_state_nxt = ST_MONITOR;
          w_wcnt_nxt  = '0;
        end else begin
          w_wcnt_nxt = r_wcnt + 1'b1;
        end
      end
      ST_MONITOR: begin
        // Clear takes priority over a coincident threshold hit.
        if (w_clr) begin
          w_ack_nxt   = 1'b1;
          w_armed_nxt = 1'b0;
          w_state_nxt = ST_WARMUP;
          w_wcnt_nxt  = '0;
          w_dcnt_nxt  = '0;
        end else if (en && w_mis) begin
          if (r_dcnt == CNT_W'(THRESH - 1)) begin
            w_state_nxt       = ST_FAULT;
            w_fault_nxt       = 1'b1;
            w_code_nxt[FC_HI] = w_mis_hi;
            w_code_nxt[FC_LO] = w_mis_lo;
            w_err_nxt         = (r_err == '1) ? r_err : r_err + 1'b1;
            w_dcnt_nxt        = '0;
          end else begin
            w_dcnt_nxt = r_dcnt + 1'b1;
          end
        end else begin
          w_dcnt_nxt = '0;
        end
      end
      ST_FAULT: begin
        if (w_clr) begin
          w_ack_nxt   = 1'b1;
          w_armed_nxt = 1'b0;
          w_state_nxt = ST_CLEAR;
          w_fault_nxt = 1'b0;
          w_code_nxt  = 2'b00;
        end
      end
      ST_CLEAR: begin
        w_state_nxt = ST_WARMUP;
        w_wcnt_nxt  = '0;
        w_dcnt_nxt  = '0;
      end
      default: begin
        w_state_nxt = ST_WARMUP;
      end
    endcase
  end

  assign clr_ack    = r_ack;
  assign fault      = r_fault;
  assign fault_code = r_code;
  assign err_cnt    = r_err;

endmodule

// File: tb/tb_tie_level_monitor.sv
// Scoreboard bench: expectations queued with a due cycle at stimulus time, checked on the falling edge.
module tb_tie_level_monitor;

  localparam int S_FAULT  = 0;
  localparam int S_CODE   = 1;
  localparam int S_ERR    = 2;
  localparam int S_ACK    = 3;
  localparam int S_ACKCNT = 4;
  localparam int S_FAULT2 = 5;
  localparam int S_CODE2  = 6;
  localparam int S_ERR2   = 7;
  localparam int S_ACK2   = 8;

  typedef struct {
    int         due;
    int         sel;
    string      tag;
    logic [7:0] exp;
  } exp_t;

  logic       ck = 1'b0;
  logic       rst, en, tie_hi, tie_lo, clr_req;
  logic       clr_ack, fault;
  logic [1:0] fault_code;
  logic [7:0] err_cnt;
  logic       tie_hi2, tie_lo2, clr2;
  logic       ack2, fault2;
  logic [1:0] code2;
  logic [1:0] err2;

  int   cyc = 0;
  int   ack_cnt = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];

  tie_level_monitor #(.WARMUP(3), .THRESH(4), .CNT_W(8)) dut (
    .ck(ck), .rst(rst), .en(en), .tie_hi(tie_hi), .tie_lo(tie_lo),
    .clr_req(clr_req), .clr_ack(clr_ack), .fault(fault),
    .fault_code(fault_code), .err_cnt(err_cnt)
  );

  tie_level_monitor #(.WARMUP(3), .THRESH(1), .CNT_W(2)) dut2 (
    .ck(ck), .rst(rst), .en(en), .tie_hi(tie_hi2), .tie_lo(tie_lo2),
    .clr_req(clr2), .clr_ack(ack2), .fault(fault2),
    .fault_code(code2), .err_cnt(err2)
  );

  always #5 ck = ~ck;

  always @(posedge ck) begin
    cyc <= cyc + 1;
    if (clr_ack) ack_cnt <= ack_cnt + 1;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] obs(input int sel);
    case (sel)
      S_FAULT:  obs = {7'd0, fault};
      S_CODE:   obs = {6'd0, fault_code};
      S_ERR:    obs = err_cnt;
      S_ACK:    obs = {7'd0, clr_ack};
      S_ACKCNT: obs = 8'(ack_cnt);
      S_FAULT2: obs = {7'd0, fault2};
      S_CODE2:  obs = {6'd0, code2};
      S_ERR2:   obs = {6'd0, err2};
      S_ACK2:   obs = {7'd0, ack2};
      default:  obs = 8'hee;
    endcase
  endfunction

  // Expectation for the state seen after `delta` more rising edges.
  task automatic expect_at(input int sel, input string tag, input logic [7:0] exp, input int delta);
    exp_t e;
    e.due = cyc + delta;
    e.sel = sel;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  always @(negedge ck) begin
    int i;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due == cyc) begin
        check(sb[i].tag, obs(sb[i].sel), sb[i].exp);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge ck);
    #1;
  endtask

  task automatic wait_fault2(input string tag);
    int n;
    n = 0;
    while (fault2 !== 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    if (fault2 !== 1'b1) check(tag, {7'd0, fault2}, 8'd1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; tie_hi = 1'b1; tie_lo = 1'b0; clr_req = 1'b0;
    tie_hi2 = 1'b1; tie_lo2 = 1'b0; clr2 = 1'b0;
    tick(3);
    rst = 1'b0;
    expect_at(S_FAULT,  "rst_fault", 8'd0, 0);
    expect_at(S_CODE,   "rst_code",  8'd0, 0);
    expect_at(S_ERR,    "rst_err",   8'd0, 0);
    expect_at(S_ACK,    "rst_ack",   8'd0, 0);
    expect_at(S_FAULT2, "rst_fault2", 8'd0, 0);
    expect_at(S_ERR2,   "rst_err2",  8'd0, 0);

    tick(50);
    expect_at(S_FAULT,  "idle_fault",  8'd0, 0);
    expect_at(S_ERR,    "idle_err",    8'd0, 0);
    expect_at(S_ACKCNT, "idle_ackcnt", 8'd0, 0);

    // tie_hi stuck low
    tie_hi = 1'b0;
    expect_at(S_FAULT, "hi_fault_early", 8'd0, 5);
    expect_at(S_FAULT, "hi_fault",       8'd1, 6);
    expect_at(S_CODE,  "hi_code",        8'd1, 6);
    expect_at(S_ERR,   "hi_err",         8'd1, 6);
    tick(8);

    // held clear request with tie_hi still stuck
    clr_req = 1'b1;
    expect_at(S_ACK,   "clr_ack",        8'd1, 1);
    expect_at(S_FAULT, "clr_fault",      8'd0, 1);
    expect_at(S_CODE,  "clr_code",       8'd0, 1);
    expect_at(S_ACK,   "clr_ack_pulse",  8'd0, 2);
    expect_at(S_FAULT, "refault_early",  8'd0, 8);
    expect_at(S_FAULT, "refault",        8'd1, 9);
    expect_at(S_ERR,   "refault_err",    8'd2, 9);
    tick(5);
    clr_req = 1'b0;
    tick(6);
    expect_at(S_ACKCNT, "held_req_single_ack", 8'd1, 0);

    tie_hi = 1'b1; clr_req = 1'b1;
    tick(1);
    clr_req = 1'b0;
    tick(10);

    // tie_lo glitches: 3 on, 1 off, 3 on
    tie_lo = 1'b1; tick(3);
    tie_lo = 1'b0; tick(1);
    tie_lo = 1'b1; tick(3);
    tie_lo = 1'b0; tick(8);
    expect_at(S_FAULT, "glitch3_fault", 8'd0, 0);
    expect_at(S_ERR,   "glitch3_err",   8'd2, 0);
    tick(1);

    // 4-cycle tie_lo pulse
    tie_lo = 1'b1;
    expect_at(S_FAULT, "lo_fault_early", 8'd0, 5);
    expect_at(S_FAULT, "lo_fault",       8'd1, 6);
    expect_at(S_CODE,  "lo_code",        8'd2, 6);
    expect_at(S_ERR,   "lo_err",         8'd3, 6);
    tick(4);
    tie_lo = 1'b0;
    tick(4);
    clr_req = 1'b1; tick(1); clr_req = 1'b0;
    tick(10);

    // monitor disabled while tie_hi is stuck
    en = 1'b0; tie_hi = 1'b0;
    tick(20);
    expect_at(S_FAULT, "en0_fault", 8'd0, 0);
    tick(1);
    en = 1'b1;
    expect_at(S_FAULT, "en1_fault_early", 8'd0, 3);
    expect_at(S_FAULT, "en1_fault",       8'd1, 4);
    expect_at(S_ERR,   "en1_err",         8'd4, 4);
    tick(6);
    en = 1'b0;
    tick(3);
    expect_at(S_FAULT, "sticky_en0_fault", 8'd1, 0);
    expect_at(S_CODE,  "sticky_en0_code",  8'd1, 0);
    tick(1);
    en = 1'b1;
    tie_hi = 1'b1; clr_req = 1'b1; tick(1); clr_req = 1'b0;
    tick(10);

    // clear coincident with threshold hit
    tie_hi = 1'b0;
    expect_at(S_ACK,   "race_ack",           8'd1, 6);
    expect_at(S_FAULT, "race_fault",         8'd0, 6);
    expect_at(S_ERR,   "race_err",           8'd4, 6);
    expect_at(S_FAULT, "race_refault_early", 8'd0, 12);
    expect_at(S_FAULT, "race_refault",       8'd1, 13);
    expect_at(S_ERR,   "race_refault_err",   8'd5, 13);
    tick(5);
    clr_req = 1'b1; tick(1); clr_req = 1'b0;
    tick(10);
    expect_at(S_ACKCNT, "total_acks", 8'd5, 0);
    tick(1);

    // saturation on the 2-bit counter instance
    tie_hi2 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      wait_fault2($sformatf("wait_fault2_%0d", k));
      expect_at(S_ERR2,  $sformatf("sat_err2_%0d", k), (k > 3) ? 8'd3 : 8'(k), 0);
      expect_at(S_CODE2, $sformatf("sat_code2_%0d", k), 8'd1, 0);
      if (k < 6) begin
        clr2 = 1'b1; tick(1);
        clr2 = 1'b0; tick(1);
      end
    end

    // reset while both instances sit in FAULT
    rst = 1'b1;
    expect_at(S_FAULT2, "mid_rst_fault2", 8'd0, 1);
    expect_at(S_CODE2,  "mid_rst_code2",  8'd0, 1);
    expect_at(S_ERR2,   "mid_rst_err2",   8'd0, 1);
    expect_at(S_ACK2,   "mid_rst_ack2",   8'd0, 1);
    expect_at(S_FAULT,  "mid_rst_fault",  8'd0, 1);
    expect_at(S_ERR,    "mid_rst_err",    8'd0, 1);
    tick(1);
    rst = 1'b0;
    tick(3);

    check("scoreboard_drained", 8'(sb.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
